// File: rtl/rv32i_ref_run_ctrl.sv
// Run sequencer for the rv32i_ref reference model: backdoor-load window, free or lockstep
// execution gated by DUT commit credits, end-of-test detection and status latching.
module rv32i_ref_run_ctrl #(
  parameter int LOAD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CREDIT_W       = 4,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                lockstep_en,
  input  logic                dut_commit,
  input  logic                ref_retire,
  input  logic                ref_ebreak,
  input  logic                ref_ecall,
  input  logic                ref_illegal,
  output logic                ref_run,
  output logic                load_active,
  output logic                done,
  output logic [2:0]          status,
  output logic [CNT_W-1:0]    instr_cnt,
  output logic [CREDIT_W-1:0] credits
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LD_W  = $clog2(LOAD_CYCLES + 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  typedef enum logic [2:0] {
    ST_NONE       = 3'd0,
    ST_EBREAK     = 3'd1,
    ST_ECALL      = 3'd2,
    ST_ILLEGAL    = 3'd3,
    ST_TIMEOUT    = 3'd4,
    ST_CREDIT_OVF = 3'd5
  } status_t;

  state_t              state, state_nxt;
  status_t             status_q, status_nxt;
  logic [LD_W-1:0]     load_cnt, load_cnt_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;
  logic                lockstep_q, lockstep_nxt;
  logic [CREDIT_W-1:0] credits_q, credits_nxt;
  logic [CNT_W-1:0]    instr_cnt_q, instr_cnt_nxt;

  logic start_ok, inc, dec, ovf;

  assign ref_run     = (state == RUN) && (!lockstep_q || credits_q != '0);
  assign load_active = (state == LOAD);
  assign done        = (state == DONE);
  assign status      = status_q;
  assign instr_cnt   = instr_cnt_q;
  assign credits     = credits_q;

  // The credits!=0 guard only matters in free-run, where ref_run is high at zero credits.
  assign start_ok = start && (state == IDLE || state == DONE);
  assign inc      = dut_commit;
  assign dec      = ref_retire && ref_run && (credits_q != '0);
  assign ovf      = lockstep_q && (credits_q == CREDIT_MAX) && inc && !dec;

  always_comb begin
    // NOTE: every signal written here is defaulted first so no path leaves it unassigned,
    // which would infer a latch.
    state_nxt     = state;
    status_nxt    = status_q;
    load_cnt_nxt  = load_cnt;
    tmo_cnt_nxt   = tmo_cnt;
    lockstep_nxt  = lockstep_q;
    credits_nxt   = credits_q;
    instr_cnt_nxt = instr_cnt_q;

    if (state == LOAD || state == RUN) begin
      if (inc && !dec && credits_q != CREDIT_MAX) credits_nxt = credits_q + CREDIT_W'(1);
      else if (dec && !inc)                       credits_nxt = credits_q - CREDIT_W'(1);
    end

    unique case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_nxt     = LOAD;
          status_nxt    = ST_NONE;
          load_cnt_nxt  = '0;
          tmo_cnt_nxt   = '0;
          lockstep_nxt  = lockstep_en;
          credits_nxt   = '0;
          instr_cnt_nxt = '0;
        end
      end
      LOAD: begin
        load_cnt_nxt = load_cnt + LD_W'(1);
        if (load_cnt == LD_W'(LOAD_CYCLES - 1)) state_nxt = RUN;
      end
      RUN: begin
        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        if (ref_retire) instr_cnt_nxt = instr_cnt_q + CNT_W'(1);
        if (ref_illegal)                                  status_nxt = ST_ILLEGAL;
        else if (ref_ebreak)                              status_nxt = ST_EBREAK;
        else if (ref_ecall)                               status_nxt = ST_ECALL;
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1))   status_nxt = ST_TIMEOUT;
        else if (ovf)                                     status_nxt = ST_CREDIT_OVF;
        if (status_nxt != ST_NONE) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      status_q    <= ST_NONE;
      load_cnt    <= '0;
      tmo_cnt     <= '0;
      lockstep_q  <= 1'b0;
      credits_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      state       <= state_nxt;
      status_q    <= status_nxt;
      load_cnt    <= load_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      lockstep_q  <= lockstep_nxt;
      credits_q   <= credits_nxt;
      instr_cnt_q <= instr_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rv32i_ref_run_ctrl.sv
// Directed bench for rv32i_ref_run_ctrl: a vector table for the lockstep/credit flow plus
// hand-written sequences for free run, overflow, timeout/restart and asynchronous reset.
module tb_rv32i_ref_run_ctrl;

  localparam int CREDIT_W = 4;
  localparam int CNT_W    = 32;
  localparam int TMO      = 50;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start, lockstep_en, dut_commit, ref_retire, ref_ebreak, ref_ecall, ref_illegal;
  logic                ref_run, load_active, done;
  logic [2:0]          status;
  logic [CNT_W-1:0]    instr_cnt;
  logic [CREDIT_W-1:0] credits;

  int n_tests = 0;
  int n_fail  = 0;

  rv32i_ref_run_ctrl #(
    .LOAD_CYCLES(2), .TIMEOUT_CYCLES(TMO), .CREDIT_W(CREDIT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lockstep_en(lockstep_en),
    .dut_commit(dut_commit), .ref_retire(ref_retire), .ref_ebreak(ref_ebreak),
    .ref_ecall(ref_ecall), .ref_illegal(ref_illegal), .ref_run(ref_run),
    .load_active(load_active), .done(done), .status(status),
    .instr_cnt(instr_cnt), .credits(credits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, ls, dc, rr, eb, ec, il;
    logic run, la, dn;
    int   stat, cnt, cr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, ls, dc, rr, eb, ec, il);
    start = st; lockstep_en = ls; dut_commit = dc; ref_retire = rr;
    ref_ebreak = eb; ref_ecall = ec; ref_illegal = il;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int run_cycles;
    bit seen_done;

    //        st ls dc rr eb ec il  run la dn stat cnt cr
    vecs[0]  = '{1, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0};  // start; commit in IDLE ignored
    vecs[1]  = '{0, 0, 1, 1, 1, 0, 0,  0, 1, 0, 0, 0, 1};  // LOAD: ebreak/retire ignored
    vecs[2]  = '{0, 0, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 2};  // LOAD: illegal ignored, to RUN
    vecs[3]  = '{0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 1, 1};
    vecs[4]  = '{0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 2, 1};  // commit+retire: credits flat
    vecs[5]  = '{0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 3, 0};  // last credit consumed: stall
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 3, 1};
    vecs[8]  = '{0, 0, 1, 1, 0, 1, 0,  0, 0, 1, 2, 4, 1};  // ecall, retire still counted
    vecs[9]  = '{0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 2, 4, 1};  // DONE sticky
    vecs[10] = '{1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0};  // restart free-run clears
    vecs[11] = '{1, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0};  // start in LOAD ignored
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 1, 1, 0, 1,  0, 0, 1, 3, 1, 0};  // illegal beats ebreak

    idle_inputs();
    rst_n = 1'b0;
    #22;
    rst_n = 1'b1;
    tick();

    check("reset ref_run", ref_run, 0);
    check("reset load_active", load_active, 0);
    check("reset done", done, 0);
    check("reset status", status, 0);
    check("reset instr_cnt", instr_cnt, 0);
    check("reset credits", credits, 0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].st, vecs[i].ls, vecs[i].dc, vecs[i].rr, vecs[i].eb, vecs[i].ec, vecs[i].il);
      tick();
      check($sformatf("vec%0d ref_run", i), ref_run, vecs[i].run);
      check($sformatf("vec%0d load_active", i), load_active, vecs[i].la);
      check($sformatf("vec%0d done", i), done, vecs[i].dn);
      check($sformatf("vec%0d status", i), status, vecs[i].stat);
      check($sformatf("vec%0d instr_cnt", i), instr_cnt, vecs[i].cnt);
      check($sformatf("vec%0d credits", i), credits, vecs[i].cr);
    end

    // Free run: two load cycles, then ebreak on the 10th retire.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    check("free load cycle1", load_active, 1);
    tick();
    check("free load cycle2", load_active, 1);
    tick();
    check("free load end", load_active, 0);
    check("free ref_run", ref_run, 1);
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 0, 1, (i == 10), 0, 0);
      tick();
    end
    idle_inputs();
    check("free done", done, 1);
    check("free status", status, 1);
    check("free instr_cnt", instr_cnt, 10);

    // Lockstep credit overflow.
    drive(1, 1, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    tick();
    tick();
    check("ovf run stalled at zero credits", ref_run, 0);
    for (int i = 0; i < 15; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      tick();
    end
    check("ovf credits max", credits, 15);
    check("ovf not yet done", done, 0);
    tick();
    idle_inputs();
    check("ovf done", done, 1);
    check("ovf status", status, 5);
    check("ovf credits hold", credits, 15);

    // Timeout: count RUN cycles until done.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    tick();
    run_cycles = 0;
    seen_done  = 0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      tick();
      if (done) seen_done = 1;
      else if (ref_run) run_cycles++;
    end
    check("timeout reached", seen_done, 1);
    check("timeout run cycles", run_cycles, TMO);
    check("timeout status", status, 4);

    // Restart in lockstep, build credits=5/instr_cnt=7, then reset mid-RUN.
    drive(1, 1, 0, 0, 0, 0, 0);
    tick();
    check("restart status", status, 0);
    check("restart instr_cnt", instr_cnt, 0);
    check("restart load_active", load_active, 1);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0);
      tick();
    end
    idle_inputs();
    check("pre-reset credits", credits, 5);
    check("pre-reset instr_cnt", instr_cnt, 7);
    check("pre-reset ref_run", ref_run, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset ref_run", ref_run, 0);
    check("async reset credits", credits, 0);
    check("async reset instr_cnt", instr_cnt, 0);
    check("async reset status", status, 0);
    check("async reset done", done, 0);
    check("async reset load_active", load_active, 0);
    #10;
    rst_n = 1'b1;
    tick();
    check("post-reset idle ref_run", ref_run, 0);
    check("post-reset idle load_active", load_active, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    idle_inputs();
    check("post-reset start accepted", load_active, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
